// File: rtl/c7b_ifu_pkg.sv
// Shared types and helpers for the c7b instruction fetch unit.
// Holds the redirect-select encoding, the default reset vector and the fetch-align helper.
package c7b_ifu_pkg;

  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BRN  = 3'd1,
    SEL_ISR  = 3'd2,
    SEL_ERT  = 3'd3,
    SEL_HOLD = 3'd4
  } pc_sel_e;

  localparam logic [31:0] C7B_RESET_PC = 32'h1c00_0000;

  // Clears the byte offset within a fetch block; bytes must be a power of two.
  function automatic logic [63:0] fetch_align(input logic [63:0] addr, input int unsigned bytes);
    return addr & ~(64'(bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/c7bifu_ftq.sv
// Fetch tracking queue: circular FIFO of {addr, kill} for in-flight ICU requests.
// The caller guarantees push only when not full and pop only when not empty.
module c7bifu_ftq #(
  parameter int AW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic          i_pop,
  input  logic          i_kill_all,
  output logic [AW-1:0] o_head_addr,
  output logic          o_head_kill,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // kill_all marks only entries already present; the same-cycle push lands clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kill   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_kill_all) r_kill <= '1;
      if (i_push) begin
        r_addr[r_wr_ptr] <= i_push_addr;
        r_kill[r_wr_ptr] <= 1'b0;
        r_wr_ptr         <= next_ptr(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_kill = r_kill[r_rd_ptr];
  assign o_count     = r_cnt;
  assign o_full      = (r_cnt == CW'(DEPTH));
  assign o_empty     = (r_cnt == '0);

endmodule

// File: rtl/c7bifu_pfgen.sv
// Prefetch address generator: picks the fetch address (redirect or sequential PC),
// raises ICU requests, and tags returning data with its PC, suppressing flushed responses.
module c7bifu_pfgen
  import c7b_ifu_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          FETCH_BYTES = 8,
  parameter logic [31:0] RESET_PC    = C7B_RESET_PC,
  parameter int          MAX_OUTST   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ifu_stall,
  output logic                         ifu_icu_req_ic1,
  output logic [AW-1:0]                ifu_icu_addr_ic1,
  input  logic                         icu_ifu_ack_ic1,
  input  logic                         icu_ifu_data_valid_ic2,
  input  logic                         exu_ifu_except,
  input  logic [AW-1:0]                exu_ifu_isr_addr,
  input  logic                         exu_ifu_ertn,
  input  logic [AW-1:0]                exu_ifu_ert_addr,
  input  logic                         exu_ifu_branch,
  input  logic [AW-1:0]                exu_ifu_brn_addr,
  output logic                         ifu_data_vld_ic2,
  output logic [AW-1:0]                ifu_fetch_pc_ic2,
  output logic [$clog2(MAX_OUTST):0]   ifu_outst_cnt
);

  localparam int            CW     = $clog2(MAX_OUTST) + 1;
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  logic [AW-1:0] r_pc;
  logic          r_reset_q;

  pc_sel_e       w_sel;
  logic          w_redirect;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_pc_inc;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_head_addr;
  logic          w_head_kill;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  assign w_redirect = exu_ifu_except | exu_ifu_ertn | exu_ifu_branch;

  // Handshake: req/addr are held until a cycle with req & ack; that cycle is the transfer.
  assign w_req  = !reset & !r_reset_q & !ifu_stall & !w_full;
  assign w_push = w_req & icu_ifu_ack_ic1;
  assign w_pop  = icu_ifu_data_valid_ic2 & !w_empty & !reset;

  always_comb begin
    w_sel = SEL_HOLD;
    if (exu_ifu_except)      w_sel = SEL_ISR;
    else if (exu_ifu_ertn)   w_sel = SEL_ERT;
    else if (exu_ifu_branch) w_sel = SEL_BRN;
    else if (w_push)         w_sel = SEL_INC;
  end

  always_comb begin
    case (w_sel)
      SEL_ISR: w_addr = exu_ifu_isr_addr;
      SEL_ERT: w_addr = exu_ifu_ert_addr;
      SEL_BRN: w_addr = exu_ifu_brn_addr;
      default: w_addr = r_pc;
    endcase
  end

  assign w_pc_inc = AW'(fetch_align(64'(w_addr), FETCH_BYTES)) + AW'(FETCH_BYTES);

  always_ff @(posedge clk) begin
    r_reset_q <= reset;
    if (reset)           r_pc <= RST_PC;
    else if (w_push)     r_pc <= w_pc_inc;
    else if (w_redirect) r_pc <= w_addr;
  end

  c7bifu_ftq #(
    .AW    (AW),
    .DEPTH (MAX_OUTST),
    .CW    (CW)
  ) u_ftq (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (w_addr),
    .i_pop       (w_pop),
    .i_kill_all  (w_redirect & !reset),
    .o_head_addr (w_head_addr),
    .o_head_kill (w_head_kill),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign ifu_icu_req_ic1  = w_req;
  assign ifu_icu_addr_ic1 = reset ? RST_PC : w_addr;
  assign ifu_data_vld_ic2 = w_pop & !w_head_kill & !w_redirect;
  assign ifu_fetch_pc_ic2 = w_pop ? w_head_addr : '0;
  assign ifu_outst_cnt    = reset ? '0 : w_count;

endmodule
